// File: rtl/barcode_entry_pkg.sv
// Shared definitions for the barcode entry block.
//   state_t      : entry FSM states (IDLE, ENTRY, HOLD)
//   KEY_*        : bit positions of the pushbuttons inside KEY[3:0]
//   BCD_*        : BCD value produced by each digit key
//   digit_of()   : resolves colliding digit presses, highest key wins
package barcode_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int KEY_D1    = 3;
  localparam int KEY_D2    = 2;
  localparam int KEY_D3    = 1;
  localparam int KEY_ENTER = 0;

  localparam logic [3:0] BCD_D1 = 4'd1;
  localparam logic [3:0] BCD_D2 = 4'd2;
  localparam logic [3:0] BCD_D3 = 4'd3;

  // Only called when at least one digit key fired; D3 is the fall-through.
  function automatic logic [3:0] digit_of(input logic d1, input logic d2);
    if (d1)      return BCD_D1;
    else if (d2) return BCD_D2;
    else         return BCD_D3;
  endfunction

endpackage

// File: rtl/barcode_entry_key_debouncer.sv
// Per-key conditioning: two-flop synchronizer, stability counter and
// press detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw active-low pushbutton level
//   press      : one-cycle pulse on an accepted high-to-low transition
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      // Counter tracks how many consecutive samples disagree with the
      // accepted level; any agreeing sample restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        // Old level high means the new level is low: that is a press.
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/barcode_entry.sv
// Pushbutton barcode entry: collects NUM_DIGITS BCD digits from three
// digit keys, presents the code with a valid/ready handshake.
//   CLOCK_50   : system clock          RESET_N   : async active-low reset
//   KEY[3:0]   : raw active-low keys   entry_en  : entry mode, low aborts
//   code_ready : downstream accept     code      : captured BCD code
//   code_valid : code awaiting accept  digit_cnt : digits entered
//   entry_err  : one-cycle pulse on rejected enter / overflow digit
module barcode_entry
  import barcode_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [3:0]              KEY,
  input  logic                    entry_en,
  input  logic                    code_ready,
  output logic [4*NUM_DIGITS-1:0] code,
  output logic                    code_valid,
  output logic [2:0]              digit_cnt,
  output logic                    entry_err
);

  localparam int         CODE_W  = 4 * NUM_DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(NUM_DIGITS);

  logic [3:0]        press;
  logic              digit_press;
  logic [3:0]        digit_val;
  state_t            state;
  state_t            state_next;
  logic [CODE_W-1:0] code_next;
  logic [2:0]        cnt_next;
  logic              err_next;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (CLOCK_50),
      .rst_n(RESET_N),
      .key  (KEY[i]),
      .press(press[i])
    );
  end

  assign digit_press = press[KEY_D1] | press[KEY_D2] | press[KEY_D3];
  assign digit_val   = digit_of(press[KEY_D1], press[KEY_D2]);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      code      <= '0;
      digit_cnt <= '0;
      entry_err <= 1'b0;
    end else begin
      state     <= state_next;
      code      <= code_next;
      digit_cnt <= cnt_next;
      entry_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    code_next  = code;
    cnt_next   = digit_cnt;
    err_next   = 1'b0;
    if (!entry_en) begin
      state_next = ST_IDLE;
      code_next  = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_ENTRY;
          code_next  = '0;
          cnt_next   = '0;
        end
        ST_ENTRY: begin
          // Enter outranks any digit pressed in the same cycle.
          if (press[KEY_ENTER]) begin
            if (digit_cnt == MAX_CNT) begin
              state_next = ST_HOLD;
            end else begin
              err_next  = 1'b1;
              code_next = '0;
              cnt_next  = '0;
            end
          end else if (digit_press) begin
            if (digit_cnt < MAX_CNT) begin
              code_next = {code[CODE_W-5:0], digit_val};
              cnt_next  = digit_cnt + 3'd1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (code_ready) begin
            state_next = ST_ENTRY;
            code_next  = '0;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          code_next  = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    code_valid = (state == ST_HOLD);
  end

endmodule

// File: tb/tb_barcode_entry.sv
module tb_barcode_entry;

  localparam int ND = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic        entry_en;
  logic        code_ready;
  logic [15:0] code;
  logic        code_valid;
  logic [2:0]  digit_cnt;
  logic        entry_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  // Reference model: list of accepted digits, hold flag, expected error pulses.
  int digits_q[$];
  bit holding = 0;
  int exp_err = 0;

  barcode_entry #(.DEBOUNCE_CYCLES(5), .NUM_DIGITS(ND)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .KEY       (KEY),
    .entry_en  (entry_en),
    .code_ready(code_ready),
    .code      (code),
    .code_valid(code_valid),
    .digit_cnt (digit_cnt),
    .entry_err (entry_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (entry_err === 1'b1) err_seen++;

  initial begin
    #2ms;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] v = 16'h0;
    foreach (digits_q[i]) v = (v << 4) | 16'(digits_q[i]);
    return v;
  endfunction

  function automatic void model_press(input logic [3:0] mask);
    if (holding) return;
    if (mask[0]) begin
      if (digits_q.size() == ND) holding = 1;
      else begin exp_err++; digits_q.delete(); end
    end else if (mask[3:1] != 3'b000) begin
      if (digits_q.size() < ND) digits_q.push_back(mask[3] ? 1 : (mask[2] ? 2 : 3));
      else exp_err++;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_code"},  32'(code),       32'(model_code()));
    check({tag, "_cnt"},   32'(digit_cnt),  32'(digits_q.size()));
    check({tag, "_valid"}, 32'(code_valid), 32'(holding));
    check({tag, "_err"},   32'(err_seen),   32'(exp_err));
  endtask

  // mask bit i set = KEY[i] held down long enough to be accepted
  task automatic press(input logic [3:0] mask);
    KEY = ~mask;
    cycles(10);
    KEY = 4'hF;
    cycles(12);
    model_press(mask);
  endtask

  task automatic handshake();
    code_ready = 1'b1;
    cycles(1);
    code_ready = 1'b0;
    if (holding) begin holding = 0; digits_q.delete(); end
  endtask

  initial begin
    RESET_N = 1'b0; KEY = 4'hF; entry_en = 1'b0; code_ready = 1'b0;
    cycles(3);
    check_all("reset");
    RESET_N = 1'b1;
    entry_en = 1'b1;
    cycles(3);
    check_all("after_reset");

    // 1,2,1,3 then enter
    press(4'b1000); press(4'b0100); press(4'b1000); press(4'b0010);
    check_all("four_digits");
    press(4'b0001);
    check_all("hold_1213");
    check("hold_code_literal", 32'(code), 32'h1213);
    // presses ignored while holding
    press(4'b1000); press(4'b0001);
    check_all("hold_ignore");
    handshake();
    check_all("handshake");

    // short glitch on KEY2
    KEY = 4'b1011; cycles(3); KEY = 4'hF; cycles(12);
    check_all("glitch");

    // early enter
    press(4'b1000); press(4'b0100); press(4'b0001);
    check_all("early_enter");

    // overflow digit
    press(4'b0010); press(4'b0010); press(4'b0100); press(4'b1000);
    press(4'b0100);
    check_all("overflow");
    press(4'b0001); handshake();
    check_all("overflow_done");

    // simultaneous presses: highest digit wins, enter beats digits
    press(4'b1100); press(4'b0110);
    check_all("collide_digits");
    press(4'b1001);
    check_all("collide_enter");

    // abort via entry_en after two digits
    press(4'b1000); press(4'b0100);
    entry_en = 1'b0; cycles(3);
    digits_q.delete(); holding = 0;
    check_all("abort");
    entry_en = 1'b1; cycles(3);
    press(4'b0010); press(4'b0010); press(4'b0100); press(4'b1000); press(4'b0001);
    check_all("fresh_3321");
    check("fresh_literal", 32'(code), 32'h3321);
    entry_en = 1'b0; cycles(3);
    digits_q.delete(); holding = 0;
    check_all("abort_hold");
    entry_en = 1'b1; cycles(3);

    // code_ready without valid has no effect
    press(4'b0100); press(4'b0010);
    code_ready = 1'b1; cycles(3); code_ready = 1'b0; cycles(1);
    check_all("ready_no_valid");

    // randomized sessions
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      press(4'(1 << $urandom_range(1, 3)));
      else if (r <= 7) press(4'b0001);
      else if (r == 8) handshake();
      else             press(4'($urandom_range(1, 15)));
      check_all($sformatf("rand%0d", it));
    end
    if (holding) handshake();

    // asynchronous reset mid-entry
    press(4'b1000); press(4'b0100);
    @(posedge CLOCK_50);
    #5 RESET_N = 1'b0;
    #1;
    digits_q.delete(); holding = 0;
    check("async_code",  32'(code),       32'h0);
    check("async_cnt",   32'(digit_cnt),  32'h0);
    check("async_valid", 32'(code_valid), 32'h0);
    check("async_err",   32'(entry_err),  32'h0);
    cycles(2);
    RESET_N = 1'b1;
    cycles(20);
    check_all("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barcode_entry.md
BARCODE_ENTRY -- requirements
Module: barcode_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5: clock cycles a raw key level must stay stable before it is accepted.
REQ-002 Parameter NUM_DIGITS, default 4: barcode length in digits.
REQ-003 CLOCK_50  input  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 KEY  input  4  raw pushbuttons, active-low, asynchronous to CLOCK_50; KEY[3]=digit 1, KEY[2]=digit 2, KEY[1]=digit 3, KEY[0]=enter.
REQ-006 entry_en  input  1  barcode-entry mode (driven from SW[0]); low aborts and clears entry.
REQ-007 code_ready  input  1  downstream terminal accepts the code this cycle.
REQ-008 code  output  16  captured barcode, 4-bit BCD per digit, first-entered digit in [15:12].
REQ-009 code_valid  output  1  code holds a complete barcode awaiting acceptance.
REQ-010 digit_cnt  output  3  digits entered so far, 0..NUM_DIGITS (for HEX display).
REQ-011 entry_err  output  1  one-cycle pulse on a rejected enter or an overflow digit press.

Function
REQ-012 Each KEY bit shall pass a two-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 A press event is a one-cycle pulse on the debounced high-to-low transition; release generates no event.
REQ-014 States: IDLE, ENTRY, HOLD; reset and entry_en low force IDLE.
REQ-015 IDLE: code=0, digit_cnt=0, code_valid=0; entry_en high moves to ENTRY on the next cycle.
REQ-016 ENTRY, digit press with digit_cnt<NUM_DIGITS: code shifts left 4 bits, new digit enters [3:0], digit_cnt increments, all in the same cycle.
REQ-017 ENTRY, digit press with digit_cnt=NUM_DIGITS: code unchanged, entry_err pulses.
REQ-018 ENTRY, enter press with digit_cnt=NUM_DIGITS: move to HOLD; code_valid rises on the following cycle.
REQ-019 ENTRY, enter press with digit_cnt<NUM_DIGITS: entry_err pulses, code and digit_cnt cleared to 0, remain in ENTRY.
REQ-020 Multiple press events in the same cycle: enter has priority; if only digits collide, the highest digit key (KEY[3]) wins and the others are dropped.
REQ-021 HOLD: code_valid high and code stable until a cycle with code_ready high; in that cycle the handshake completes; next cycle code=0, digit_cnt=0, code_valid=0, state ENTRY.
REQ-022 HOLD: all key presses are ignored, with no entry_err.
REQ-023 code_ready while code_valid is low has no effect.
REQ-024 entry_en falling in any state: next cycle IDLE with all outputs cleared; a pending code is discarded without a handshake.

Reset
REQ-025 RESET_N low shall asynchronously force state IDLE, code=0, code_valid=0, digit_cnt=0, entry_err=0, synchronizers and debouncers to the released (high) level, and debounce counters to 0.
REQ-026 Reset deassertion is synchronized externally; the block does not detect a press from the reset level of the keys.

Structure
REQ-027 The shared package shall hold the state encoding, the key-index constants (KEY_D1=3, KEY_D2=2, KEY_D3=1, KEY_ENTER=0), and the BCD digit values 1..3.
REQ-028 One sub-module, key_debouncer (one instance per key: synchronizer, counter, press-pulse output), parameterized by DEBOUNCE_CYCLES.

Verification
REQ-029 entry_en=1, press KEY3,KEY2,KEY3,KEY1, each held 10 cycles, then KEY0 -> code=16'h1213, code_valid=1 while code_ready=0, digit_cnt=4.
REQ-030 With code 16'h1213 held, raise code_ready for 1 cycle -> code_valid=0, code=0, digit_cnt=0 on the next cycle; presses during HOLD change nothing.
REQ-031 Glitch KEY2 low for 3 cycles (below DEBOUNCE_CYCLES) -> no digit captured, digit_cnt unchanged.
REQ-032 Enter KEY3,KEY2 then KEY0 -> entry_err pulses 1 cycle, code=0, digit_cnt=0, code_valid=0; a fifth digit after 4 digits -> entry_err pulse, code unchanged.
REQ-033 Lower entry_en after 2 digits, then raise it again -> digit_cnt=0, code=0; a fresh 4-digit entry 3,3,2,1 -> code=16'h3321.
REQ-034 Assert RESET_N low mid-entry, without a clock edge -> all outputs 0 immediately; after release no spurious press event occurs.
